// File: rtl/debounce_pulse_gen.sv
// debounce_pulse_gen
//   Turns a raw, possibly bouncing 1-bit input into a clean debounced level
//   with single-cycle rising/falling edge pulses, and keeps a wrapping count
//   of accepted rising edges. Intended to feed a downstream flop with
//   en = rise_o and d = level_o, so the flop only ever captures qualified
//   0->1 transitions.
//
// Parameters
//   STABLE_CYCLES : cycles the synchronized input must hold a new value
//                   before it is accepted (2..65535)
//   RESET_LEVEL   : level_o and synchronizer value after reset
//   CNT_W         : width of rise_cnt_o
//
// Ports
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      synchronous active-high reset
//   btn_i      in   1      raw asynchronous input
//   level_o    out  1      debounced level (registered)
//   rise_o     out  1      one-cycle pulse on accepted 0->1 (registered)
//   fall_o     out  1      one-cycle pulse on accepted 1->0 (registered)
//   rise_cnt_o out  CNT_W  accepted rising edges, wraps modulo 2^CNT_W
module debounce_pulse_gen #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          RESET_LEVEL   = 1'b0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             btn_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] rise_cnt_o
);

    localparam int unsigned    CW   = $clog2(STABLE_CYCLES) + 1;
    // The cycle that enters a WAIT state already counts as the first
    // stable sample, so acceptance happens when cnt reaches STABLE_CYCLES-1.
    localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    state_t        state;
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1         <= RESET_LEVEL;
            s2         <= RESET_LEVEL;
            state      <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
            cnt        <= '0;
            level_o    <= RESET_LEVEL;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
            rise_cnt_o <= '0;
        end else begin
            // Two-flop synchronizer; only s2 is seen by the FSM.
            s1     <= btn_i;
            s2     <= s1;
            // Pulses default low so each lasts exactly one cycle.
            rise_o <= 1'b0;
            fall_o <= 1'b0;

            case (state)
                STABLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end

                WAIT_HI: begin
                    if (!s2) begin
                        // Bounce back to the current level: restart from zero.
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        level_o    <= 1'b1;
                        rise_o     <= 1'b1;
                        rise_cnt_o <= rise_cnt_o + CNT_W'(1);
                        state      <= STABLE_HI;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STABLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end

                WAIT_LO: begin
                    if (s2) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        level_o <= 1'b0;
                        fall_o  <= 1'b1;
                        state   <= STABLE_LO;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/debounce_pulse_gen.md
# debounce_pulse_gen

- Conditions a raw, possibly bouncing 1-bit input into a clean level plus single-cycle edge pulses.
- Sits directly upstream of the data flip-flop stage:
  - `rise_o` drives its `en_i`.
  - `level_o` drives its `d_i`.
  - The flip-flop therefore captures only debounced, qualified transitions.
- Also keeps a wrapping count of qualified rising edges for bench observation.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive cycles a new synchronized value must hold before it is accepted. Legal range is 2..65535.
- `RESET_LEVEL`, default 0: value of `level_o` and of both synchronizer stages after reset.
- `CNT_W`, default 8: width of `rise_cnt_o`.

Ports:
- `clk_i`  in  1: single clock; all state updates on its rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `btn_i`  in  1: raw asynchronous input.
- `level_o`  out  1: debounced level, registered.
- `rise_o`  out  1: one-cycle pulse on an accepted 0→1 transition, registered.
- `fall_o`  out  1: one-cycle pulse on an accepted 1→0 transition, registered.
- `rise_cnt_o`  out  `CNT_W`: count of accepted rising edges; wraps modulo 2^`CNT_W`.

## Operation
- **Synchronizer:** two flops, `btn_i` → s1 → s2. s2 is the only value the FSM reads.
- **Stability counter:** `cnt`, width `$clog2(STABLE_CYCLES)+1`.
- **FSM states:** `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`.
- **Reset:** state = `STABLE_HI` if `RESET_LEVEL`=1, else `STABLE_LO`. Outputs on reset:
  - s1 = s2 = `level_o` = `RESET_LEVEL`
  - `cnt` = 0
  - `rise_o` = `fall_o` = 0
  - `rise_cnt_o` = 0
- **Reset priority:** `rst_i` high overrides everything, including a mid-wait state or a pulse being generated.
- **`STABLE_LO`:** if s2=1 go to `WAIT_HI`, `cnt`=1; otherwise stay, `cnt`=0.
- **`WAIT_HI`:**
  - If s2=0, return to `STABLE_LO` with `cnt`=0. This is a glitch: no pulse, `level_o` unchanged.
  - If s2=1 and `cnt`=`STABLE_CYCLES`-1:
    - `level_o`←1, `rise_o`←1 for one cycle, `rise_cnt_o`←`rise_cnt_o`+1.
    - go to `STABLE_HI`, `cnt`=0.
  - Otherwise `cnt`++.
- **`STABLE_HI` / `WAIT_LO`:** mirror images of the above. An accepted transition asserts `fall_o`, and `rise_cnt_o` is unchanged.
- **Pulse exclusivity:** `rise_o` and `fall_o` are never high in the same cycle. Each is high for exactly one cycle per accepted transition.
- **Counter wrap:** `rise_cnt_o` wraps from 2^`CNT_W`-1 to 0 with no flag.
- **Bounce during wait:** any return of s2 to the current `level_o` while in a WAIT state restarts qualification from zero.

## Timing
- Take `btn_i` changing and held stable, first sampled at edge k:
  - s1 changes after edge k.
  - s2 changes after edge k+1.
  - The FSM enters WAIT at edge k+2.
  - `level_o` and the pulse change after edge k+1+`STABLE_CYCLES`.
- Latency is therefore `STABLE_CYCLES`+1 edges after the first sampling edge; for default 4, after edge k+5.
- A pulse of s2 lasting fewer than `STABLE_CYCLES` cycles produces no output change.
- A pulse of s2 lasting exactly `STABLE_CYCLES` cycles is accepted.
- `rise_o` is high during the same cycle in which `level_o` first reads 1.
- A downstream flip-flop with `en_i`=`rise_o` and `d_i`=`level_o` captures 1 at the following edge.
- Minimum spacing between two accepted transitions is `STABLE_CYCLES` cycles after the first pulse.
- Reset asserted at edge r: all outputs read their reset values after edge r. Qualification resumes at the first edge with `rst_i`=0, reading s2 = `RESET_LEVEL`.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `CNT_W`=8, clock period 10.
- **Reset values:** hold `rst_i`=1 for 2 cycles, `btn_i`=1 → `level_o`=0, `rise_o`=`fall_o`=0, `rise_cnt_o`=0; no pulse until 5 edges after release.
- **Clean rise:** `btn_i` 0→1 before edge k, held → `level_o`=1 and `rise_o`=1 after edge k+5 only; `rise_o`=0 after k+6; `rise_cnt_o`=1.
- **Bounce rejected:**
  - Stimulus: `btn_i` toggles 1,0,1,0 every cycle, then settles at 1.
  - Required: no `rise_o` during toggling; exactly one `rise_o`, 5 edges after the final settle edge.
- **Boundary glitch:**
  - `btn_i` high for exactly 3 cycles → no change.
  - `btn_i` high for exactly 4 cycles → one `rise_o`.
  - The following fall produces one `fall_o`; `rise_cnt_o`=1.
- **Wrap:** 256 clean press/release pairs → `rise_cnt_o` returns to 0; 256 `rise_o` and 256 `fall_o` pulses total.
- **Reset mid-wait:**
  - Assert `rst_i` for 1 cycle while in `WAIT_HI` with `cnt`=3.
  - Required: no `rise_o` is emitted, `level_o`=0, and qualification restarts fully, with `rise_o` 5 edges after reset release.
